mux_scan_ctrl: RTL and testbench
================================

// Module: mux_scan_ctrl
// PURPOSE
//  Upstream controller for the 4:1 mux stage: drives the mux sel lines, walks the enabled
//  channels in ascending order, waits a settle time per channel, samples the mux output z
//  and assembles a 4-bit snapshot word. The word is handed downstream over a valid/ready
//  handshake. Sits between the mux and the consumer of channel snapshots.
// PARAMETERS
//  SETTLE_CYCLES  2  cycles sel is held per enabled channel before z is sampled (legal >= 1)
//  CNT_W          4  settle counter width; must satisfy 2**CNT_W >= SETTLE_CYCLES
// PORTS
//  clk         in   1  sole clock, all state on rising edge
//  rst         in   1  synchronous, active-high reset
//  start       in   1  begin a scan (sampled only in IDLE)
//  chan_en     in   4  channel enable mask, latched on accepted start
//  z           in   1  mux output for the currently driven sel
//  sel         out  2  mux select
//  busy        out  1  high in SCAN and DONE
//  dout        out  4  snapshot; bit k = sampled z of channel k, 0 if channel k disabled
//  dout_valid  out  1  snapshot available
//  dout_ready  in   1  downstream accepts snapshot
// BEHAVIOUR
//  - Reset: state=IDLE, sel=2'b00, busy=0, dout=4'h0, dout_valid=0, counter=0, mask=0.
//    rst wins over every other input, including mid-scan and while dout_valid is high.
//  - FSM: IDLE -> SCAN -> DONE -> IDLE.
//  - IDLE: sel=2'b00. On start=1: latch chan_en into mask and clear dout.
//    If mask!=0, go to SCAN with sel = lowest enabled channel. If mask==0, go to DONE.
//  - SCAN: sel is held on the current channel for SETTLE_CYCLES cycles, and counter counts
//    0..SETTLE_CYCLES-1. On the edge where counter==SETTLE_CYCLES-1: dout[sel] <= z and
//    counter <= 0. Then sel steps to the next higher enabled channel in the same edge.
//    Disabled channels are skipped with zero cycle cost. If no higher enabled channel
//    exists, go to DONE and leave sel unchanged.
//  - DONE: dout_valid=1; dout and sel stay stable. On dout_valid & dout_ready, go to IDLE
//    with dout_valid=0 next cycle; dout keeps its value until the next accepted start.
//    dout_ready with dout_valid low is ignored.
//  - Latency: start edge to dout_valid=1 is 1 + N*SETTLE_CYCLES cycles, N = popcount(mask).
//    N=0 gives 1 cycle.
//  - start outside IDLE is ignored. chan_en changes after the latching edge have no effect
//    on the current scan.
//  - z is sampled only on the final settle edge. Values of z on other cycles have no effect.
//  - No combinational path from any input to any output; all outputs are registered.
// CONFIGURATION
//  MUX_SCAN_AUTO_EN defined: continuous mode. When a DONE handshake completes, the block
//    goes to SCAN directly, re-latching chan_en on that edge, without needing start.
//    If the re-latched mask is 0, it stays in DONE with dout=0. start is still accepted
//    in IDLE, which is reached only after reset.
//  Undefined: single-shot. Each scan needs a start pulse in IDLE.
// TESTING
//  1 reset mid-scan: chan_en=4'hF, start, assert rst on cycle 3 -> next cycle sel=0,
//    dout=0, dout_valid=0, busy=0.
//  2 full scan: SETTLE_CYCLES=2, chan_en=4'hF, mux in=4'b1010 -> sel walks 0,1,2,3
//    (2 cycles each); dout_valid at cycle 9 after start; dout=4'b1010.
//  3 sparse mask: chan_en=4'b1001, in=4'b1111 -> sel visits only 0 then 3;
//    dout=4'b1001; valid at cycle 5.
//  4 empty mask: chan_en=0, start -> dout_valid=1 one cycle later, dout=0, sel stays 0.
//  5 backpressure: hold dout_ready=0 for 10 cycles in DONE -> dout, sel, dout_valid stable;
//    start pulses ignored; ready=1 -> IDLE next cycle.
//  6 MUX_SCAN_AUTO_EN: chan_en=4'h3, ready tied 1, in toggled between scans -> back-to-back
//    snapshots every 1+2*SETTLE_CYCLES cycles, each matching the in[1:0] of its scan.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// Scan controller for a 4:1 mux: walks enabled channels, samples z after a settle time
// and hands a 4-bit snapshot downstream. Define MUX_SCAN_AUTO_EN for continuous rescans.
module mux_scan_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] chan_en,
    input  logic       z,
    output logic [1:0] sel,
    output logic       busy,
    output logic [3:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [3:0]       mask;
    logic             next_found;
    logic [1:0]       next_sel;

    function automatic logic [1:0] lowest_chan(input logic [3:0] m);
        lowest_chan = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (m[k]) lowest_chan = 2'(k);
        end
    endfunction

    // Next enabled channel strictly above the one currently driven; disabled ones cost nothing.
    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        next_found = 1'b0;
        next_sel   = sel;
        for (int k = 3; k >= 0; k--) begin
            if (mask[k] && (k > int'(sel))) begin
                next_found = 1'b1;
                next_sel   = 2'(k);
            end
        end
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= 2'b00;
            busy       <= 1'b0;
            dout       <= 4'h0;
            dout_valid <= 1'b0;
            counter    <= '0;
            mask       <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mask    <= chan_en;
                        dout    <= 4'h0;
                        counter <= '0;
                        busy    <= 1'b1;
                        if (chan_en != 4'h0) begin
                            state <= SCAN;
                            sel   <= lowest_chan(chan_en);
                        end else begin
                            state      <= DONE;
                            dout_valid <= 1'b1;
                        end
                    end
                end

                SCAN: begin
                    if (counter == LAST_CNT) begin
                        dout[sel] <= z;
                        counter   <= '0;
                        if (next_found) begin
                            sel <= next_sel;
                        end else begin
                            state      <= DONE;
                            dout_valid <= 1'b1;
                        end
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end

                DONE: begin
                    if (dout_ready) begin
`ifdef MUX_SCAN_AUTO_EN
                        // Rescan immediately with a freshly latched mask; an empty one re-presents zero.
                        mask    <= chan_en;
                        dout    <= 4'h0;
                        counter <= '0;
                        if (chan_en != 4'h0) begin
                            state      <= SCAN;
                            sel        <= lowest_chan(chan_en);
                            dout_valid <= 1'b0;
                        end
`else
                        state      <= IDLE;
                        sel        <= 2'b00;
                        busy       <= 1'b0;
                        dout_valid <= 1'b0;
`endif
                    end
                end

                default: begin
                    state      <= IDLE;
                    sel        <= 2'b00;
                    busy       <= 1'b0;
                    dout_valid <= 1'b0;
                    counter    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl (single-shot build): directed cases plus random
// scans compared against a transaction-level model of the expected sel trace and snapshot.
module tb_mux_scan_ctrl;

    localparam int SETTLE = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] chan_en;
    logic       z;
    logic [1:0] sel;
    logic       busy;
    logic [3:0] dout;
    logic       dout_valid;
    logic       dout_ready;

    logic [3:0] mux_in;
    logic       z_noise;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // The mux being scanned; z_noise disturbs z on cycles where it must not be sampled.
    assign z = mux_in[sel] ^ z_noise;

    mux_scan_ctrl #(
        .SETTLE_CYCLES(SETTLE),
        .CNT_W        (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .chan_en   (chan_en),
        .z         (z),
        .sel       (sel),
        .busy      (busy),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready)
    );

    task automatic check(input string tag, input logic [3:0] actual, input logic [3:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete scan transaction: the model lists enabled channels in ascending order,
    // each holds sel for SETTLE cycles, and the snapshot is the mux input masked by enables.
    task automatic run_scan(input logic [3:0] en, input logic [3:0] in, input int ready_delay,
                            input bit noisy, input bit spam);
        int         chans[$];
        int         n;
        logic [3:0] exp_dout;
        logic [3:0] exp_sel;
        chans = {};
        for (int k = 0; k < 4; k++) begin
            if (en[k]) chans.push_back(k);
        end
        n        = chans.size();
        exp_dout = in & en;
        exp_sel  = (n == 0) ? 4'd0 : 4'(chans[n-1]);

        check("idle_valid", 4'(dout_valid), 4'd0);
        chan_en = en;
        mux_in  = in;
        start   = 1'b1;
        tick;
        start = 1'b0;

        for (int t = 1; t <= n * SETTLE; t++) begin
            check("scan_sel", 4'(sel), 4'(chans[(t-1)/SETTLE]));
            check("scan_busy", 4'(busy), 4'd1);
            check("scan_valid", 4'(dout_valid), 4'd0);
            if (t == 1) check("scan_dout_clr", dout, 4'd0);
            chan_en    = 4'($urandom);
            dout_ready = spam ? 1'($urandom) : 1'b0;
            start      = spam ? 1'($urandom) : 1'b0;
            z_noise    = (noisy && (t % SETTLE != 0)) ? 1'($urandom) : 1'b0;
            tick;
        end
        z_noise    = 1'b0;
        start      = 1'b0;
        dout_ready = 1'b0;

        for (int d = 0; d <= ready_delay; d++) begin
            check("done_valid", 4'(dout_valid), 4'd1);
            check("done_busy", 4'(busy), 4'd1);
            check("done_dout", dout, exp_dout);
            check("done_sel", 4'(sel), exp_sel);
            if (d < ready_delay) begin
                start   = spam ? 1'($urandom) : 1'b0;
                chan_en = 4'($urandom);
                tick;
            end
        end
        start      = 1'b0;
        dout_ready = 1'b1;
        tick;
        dout_ready = 1'b0;
        check("ack_valid", 4'(dout_valid), 4'd0);
        check("ack_busy", 4'(busy), 4'd0);
        check("ack_sel", 4'(sel), 4'd0);
        check("ack_dout_hold", dout, exp_dout);
        tick;
        check("idle_stay_busy", 4'(busy), 4'd0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        chan_en    = 4'h0;
        mux_in     = 4'h0;
        z_noise    = 1'b0;
        dout_ready = 1'b0;
        tick;
        tick;
        check("rst_sel", 4'(sel), 4'd0);
        check("rst_busy", 4'(busy), 4'd0);
        check("rst_dout", dout, 4'd0);
        check("rst_valid", 4'(dout_valid), 4'd0);
        rst = 1'b0;
        tick;

        // Reset mid-scan
        chan_en = 4'hF;
        mux_in  = 4'hF;
        start   = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("midscan_rst_sel", 4'(sel), 4'd0);
        check("midscan_rst_dout", dout, 4'd0);
        check("midscan_rst_valid", 4'(dout_valid), 4'd0);
        check("midscan_rst_busy", 4'(busy), 4'd0);
        tick;
        check("midscan_rst_idle", 4'(busy), 4'd0);

        // Reset while a snapshot is being offered
        chan_en = 4'h0;
        start   = 1'b1;
        tick;
        start = 1'b0;
        check("done_pre_rst_valid", 4'(dout_valid), 4'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("done_rst_valid", 4'(dout_valid), 4'd0);
        check("done_rst_busy", 4'(busy), 4'd0);
        tick;

        run_scan(4'hF, 4'b1010, 0, 1'b0, 1'b0);
        run_scan(4'b1001, 4'b1111, 0, 1'b0, 1'b0);
        run_scan(4'h0, 4'hF, 0, 1'b0, 1'b0);
        run_scan(4'b0110, 4'b0101, 10, 1'b1, 1'b1);

        for (int i = 0; i < 60; i++) begin
            run_scan(4'($urandom), 4'($urandom), int'($urandom_range(0, 3)), 1'b1, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
